// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - burst-oriented word memory responder with read/write beats
//
// Purpose: accepts a burst-length header in IDLE, then consumes one beat per
// cycle with w_ready=1 until the burst count is exhausted. Each beat is either
// a write into the internal array or a read returned one cycle later.
//
// Ports:
//   w_clock   clock, rising edge
//   w_rst_n   asynchronous active-low reset
//   w_ready   beat/header enable
//   w_burst   burst-length header (nonzero in IDLE starts a burst)
//   w_addr    word address of the current beat
//   w_rw      1 = read beat, 0 = write beat
//   w_wdata   write data
//   w_rdata   read data, zero whenever w_rvalid=0
//   w_rvalid  one-cycle pulse per read beat
//   w_busy    high while in BURST
//   w_done    one-cycle pulse after the final beat
//   w_err     sticky out-of-range flag, cleared by the next accepted header
module mem_burst_responder #(
    parameter int MAIN_MEM_ADDR_WIDTH = 32,
    parameter int BURST_WIDTH         = 6,
    parameter int DATA_WIDTH          = 16,
    parameter int MEM_DEPTH           = 256
) (
    input  logic                           w_clock,
    input  logic                           w_rst_n,
    input  logic                           w_ready,
    input  logic [BURST_WIDTH-1:0]         w_burst,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr,
    input  logic                           w_rw,
    input  logic [DATA_WIDTH-1:0]          w_wdata,
    output logic [DATA_WIDTH-1:0]          w_rdata,
    output logic                           w_rvalid,
    output logic                           w_busy,
    output logic                           w_done,
    output logic                           w_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MAIN_MEM_ADDR_WIDTH-1:0] DEPTH_A = MAIN_MEM_ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [BURST_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    accept;
    logic                    beat;
    logic                    in_range;
    logic                    mem_we;
    logic [IDX_W-1:0]        idx;

    // State register
    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // The array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge w_clock) begin
        if (mem_we) begin
            mem[idx] <= w_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        accept   = (state_q == IDLE) && w_ready && (w_burst != '0);
        beat     = (state_q == BURST) && w_ready;
        in_range = (w_addr < DEPTH_A);
        idx      = w_addr[IDX_W-1:0];
        mem_we   = beat && !w_rw && in_range;

        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_d   = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = '0;

        if (accept) begin
            state_d = BURST;
            cnt_d   = w_burst;
            err_d   = 1'b0;
        end

        if (beat) begin
            cnt_d = cnt_q - BURST_WIDTH'(1);
            if (cnt_q == BURST_WIDTH'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            if (!in_range) begin
                err_d = 1'b1;
            end
            if (w_rw) begin
                rvalid_d = 1'b1;
                // Out-of-range reads still produce a beat, with zero data.
                rdata_d  = in_range ? mem[idx] : '0;
            end
        end
    end

    // Output logic
    always_comb begin
        w_busy   = (state_q == BURST);
        w_done   = done_q;
        w_err    = err_q;
        w_rvalid = rvalid_q;
        w_rdata  = rdata_q;
    end

endmodule
